sr_latch_sequencer: RTL
=======================

# sr_latch_sequencer

Clocked controller that shares one external NOR-based SR latch between `N_REQ` requesters. It round-robin arbitrates set/reset requests and drives registered `latch_s`/`latch_r` pulses of fixed width, never asserting both. After a settle gap it checks `latch_q`/`latch_qb` and reports completion and error. It sits between synchronous request logic and the gate-level latch, acting as the only legal driver of the latch's inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..16).
- `PULSE_CYC`, 2: cycles `latch_s` or `latch_r` is held high per operation (≥1).
- `SETTLE_CYC`, 2: cycles with both latch inputs low before the check (≥1).
- `INIT_CLEAR`, 1: when 1, perform one internal reset operation after reset release.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req`  in  N_REQ  request per requester; level, held until granted.
- `op`  in  N_REQ  per-requester operation: 1 = set, 0 = reset; sampled with the grant.
- `gnt`  out  N_REQ  one-hot, one-cycle grant pulse.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse for a granted operation.
- `done_id`  out  $clog2(N_REQ)  index of the requester whose operation completed; valid with `done`.
- `err`  out  1  check failure; valid only with `done`.
- `err_sticky`  out  1  set on any failed check, including the init check; cleared only by reset.
- `latch_s`  out  1  registered set drive to the latch.
- `latch_r`  out  1  registered reset drive to the latch.
- `latch_q`, `latch_qb`  in  1  latch outputs, fed back.

## Operation
- FSM states: IDLE → PULSE → SETTLE → CHECK → IDLE.
- IDLE: if any `req` bit is high at a clock edge, the round-robin winner is taken and the state moves to PULSE.
  - Round-robin search starts at `ptr`. After a grant, `ptr` becomes winner+1, mod `N_REQ`.
  - The winner's `op` bit and index are latched.
- PULSE: `gnt[winner]` is high in the first PULSE cycle only.
  - `latch_s` = latched op; `latch_r` = ~latched op.
  - Lasts exactly `PULSE_CYC` cycles.
- SETTLE: `latch_s` = `latch_r` = 0 for exactly `SETTLE_CYC` cycles.
- CHECK: lasts 1 cycle. `done` = 1 and `done_id` = latched index.
  - `err` = (`latch_q` == `latch_qb`) OR (`latch_q` != latched op).
  - A failed check sets `err_sticky`.
- Invariant: `latch_s & latch_r` is never 1, including across reset.
- Requests are sampled only in IDLE. A `req` dropped before its grant is lost; no error is raised.
- With `INIT_CLEAR`=1, the first cycle after reset release runs PULSE/SETTLE/CHECK as a reset operation.
  - No `gnt` and no `done` are issued for it.
  - `busy` stays high throughout. A failed check sets `err_sticky` only.
  - Requests wait in IDLE after it.
- Reset value of every output:
  - `gnt`=0, `busy`=0 (1 when `INIT_CLEAR`=1, from the first edge after release), `done`=0, `done_id`=0, `err`=0, `err_sticky`=0, `latch_s`=0, `latch_r`=0.
  - Internal `ptr`=0.
- Reset mid-operation: `latch_s`/`latch_r` drop to 0 asynchronously, and the FSM returns to IDLE. The abandoned operation never reports `done`.

## Timing
- Grant latency: `req` high at edge k while in IDLE → `gnt` high in cycle k+1.
- `done` occurs `PULSE_CYC`+`SETTLE_CYC` cycles after the `gnt` cycle.
- Back-to-back throughput: one operation per `PULSE_CYC`+`SETTLE_CYC`+2 cycles. IDLE lasts a minimum of 1 cycle between operations.
- Simultaneous requests: the lowest index at or above `ptr` wins, wrapping around. `ptr` wraps from `N_REQ`-1 to 0.
- `err` samples `latch_q`/`latch_qb` combinationally in the CHECK cycle. `SETTLE_CYC` must cover the latch's gate delay plus the feedback delay.

## Structure
- Package `sr_seq_pkg`:
  - `state_t` enum {IDLE, PULSE, SETTLE, CHECK}.
  - `OP_SET`=1'b1 and `OP_RESET`=1'b0.
  - Function `clog2_min1` for index width.
- Sub-module `rr_arbiter`: combinational round-robin pick from (`req`, `ptr`) → one-hot plus index.
- One shared down-counter is reloaded on entry to PULSE and SETTLE, width $clog2(max(PULSE_CYC,SETTLE_CYC)+1).

## Test plan
- Reset with `INIT_CLEAR`=1 and a gate-level latch attached → `latch_r` high for 2 cycles, no `gnt`/`done`, `latch_q`=0 and `err_sticky`=0 after 6 cycles.
- `req`=4'b0001, `op`=4'b0001 → `gnt`=0001 one cycle later, `latch_s` high 2 cycles, `done`=1 with `done_id`=0, `err`=0, `latch_q`=1.
- `req`=4'b1111 held continuously → grants in order 0, 1, 2, 3, 0, spaced 6 cycles apart; `latch_s & latch_r` never 1.
- Latch model with `latch_q` stuck at 0, set request → `done`=1 with `err`=1, and `err_sticky`=1 until reset.
- `rst_n` pulsed low in the second PULSE cycle → `latch_s`=0 immediately, no `done`, `ptr`=0, the next request from requester 3 is granted normally.

Source files
------------

// File: rtl/sr_seq_pkg.sv
// Shared types and helpers for the SR latch sequencer.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Index width that stays at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise paths that
    // never match would hold their old value and infer a latch.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
    any = found;
  end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sole driver of an external NOR SR latch: arbitrates requesters, pulses S/R,
// waits for the latch to settle and verifies its outputs.
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 2,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         op,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic                     err,
  output logic                     err_sticky,
  output logic                     latch_s,
  output logic                     latch_r,
  input  logic                     latch_q,
  input  logic                     latch_qb
);

  localparam int IW    = clog2_min1(N_REQ);
  localparam int MAXC  = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW    = $clog2(MAXC + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_l;
  logic [IW-1:0] idx_l;
  logic [IW-1:0] ptr;
  logic          init_pend;
  logic          init_op;

  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             check_fail;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  // The latch must hold exactly the latched op with complementary outputs.
  assign check_fail = (latch_q == latch_qb) || (latch_q != op_l);

  assign busy    = (state != IDLE);
  assign done_id = idx_l;
  assign err     = done & check_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_l       <= OP_RESET;
      idx_l      <= '0;
      ptr        <= '0;
      init_pend  <= INIT_CLEAR;
      init_op    <= 1'b0;
      gnt        <= '0;
      done       <= 1'b0;
      err_sticky <= 1'b0;
      latch_s    <= 1'b0;
      latch_r    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init_pend) begin
            init_pend <= 1'b0;
            init_op   <= 1'b1;
            op_l      <= OP_RESET;
            latch_s   <= 1'b0;
            latch_r   <= 1'b1;
            cnt       <= CW'(PULSE_CYC - 1);
            state     <= PULSE;
          end else if (win_any) begin
            init_op <= 1'b0;
            op_l    <= op[win_idx];
            idx_l   <= win_idx;
            ptr     <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
            gnt     <= win_oh;
            latch_s <= op[win_idx];
            latch_r <= ~op[win_idx];
            cnt     <= CW'(PULSE_CYC - 1);
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            latch_s <= 1'b0;
            latch_r <= 1'b0;
            cnt     <= CW'(SETTLE_CYC - 1);
            state   <= SETTLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            done  <= ~init_op;
            state <= CHECK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CHECK: begin
          if (check_fail) err_sticky <= 1'b1;
          state <= IDLE;
        end
        default: begin
          latch_s <= 1'b0;
          latch_r <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
